gsa_ctrl: RTL
=============

Name: gsa_ctrl

Overview:
Sequencing controller for the signed growing-sum averager. It owns the averager's configuration and admits input samples only in whole frames of 2^n_avgs samples. Averaging-length changes are applied only at frame boundaries, after the in-flight result has drained and a settle gap has elapsed. Each averaged result is tagged with a frame index for the downstream readout path.

Parameters:
N, 16, sample and result width (two's complement)
NAVG_W, 8, width of the averaging-length (log2) field
MAX_LOG2, 10, largest accepted log2 frame length; larger requests are clamped
SETTLE_CYC, 3, cycles with avg_valid held low after any configuration apply
DRAIN_TIMEOUT, 64, maximum cycles to wait for an outstanding result in DRAIN
FRAME_W, 16, frame index width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  run request, level-sensitive
cfg_n_avgs  in  NAVG_W  requested log2 frame length
cfg_update  in  1  single-cycle pulse; latch cfg_n_avgs as pending
cfg_busy  out  1  a pending configuration exists, or state is DRAIN or SETTLE
s_valid  in  1  input sample valid
s_ready  out  1  controller can accept a sample
s_data  in  N  input sample
avg_valid  out  1  sample strobe to averager
avg_x  out  N  sample to averager
avg_n_avgs  out  NAVG_W  active log2 length to averager
avg_new_dat  in  1  averager result strobe
avg_y  in  N  averager result
m_valid  out  1  result strobe, one cycle
m_data  out  N  result
m_frame  out  FRAME_W  index of the frame that produced m_data
err_unexp  out  1  sticky: result strobe arrived with nothing outstanding
err_timeout  out  1  sticky: DRAIN timed out

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state IDLE; all outputs 0, except avg_n_avgs = 1.
  - Frame index 0, sample count 0, outstanding count 0.
  - Pending configuration discarded; error flags cleared.
  - rst asserted mid-frame does the same; a partial frame is abandoned.
- Frame length L = 2^active. active = min(cfg_n_avgs, MAX_LOG2); a value of 0 gives L = 1.
- States:
  - IDLE: s_ready=0, avg_valid=0. cfg_update applies directly to active on the next cycle. enable=1 -> SETTLE.
  - SETTLE: s_ready=0, avg_valid=0 for exactly SETTLE_CYC cycles, then RUN with sample count 0. avg_n_avgs updates on SETTLE entry only and is otherwise stable.
  - RUN: s_ready=1. Accept = s_valid & s_ready. On accept, the next cycle gives avg_valid=1 and avg_x=s_data (1-cycle registered latency); otherwise avg_valid=0.
  - RUN at the boundary (Lth accept): outstanding increments. If a configuration is pending or enable=0 -> DRAIN, with s_ready=0 from the next cycle. Otherwise the count wraps to 0 and the state stays RUN, with no bubble.
  - DRAIN: s_ready=0. Wait until outstanding = 0, or DRAIN_TIMEOUT cycles pass (then set err_timeout and force outstanding to 0). On exit, apply pending to active and clear pending. enable=1 -> SETTLE, else IDLE.
- enable falling mid-frame: the frame still completes; the controller keeps s_ready=1 until the Lth accept. No partial frames are ever sent to the averager.
- cfg_update outside IDLE latches pending; last write wins. A cfg_update in the same cycle as the Lth accept takes effect at that boundary.
- Result path:
  - avg_new_dat with outstanding > 0: the next cycle gives m_valid=1, m_data=avg_y, m_frame=frame index. The frame index then increments (wrapping modulo 2^FRAME_W) and outstanding decrements.
  - avg_new_dat with outstanding = 0: the result is dropped and err_unexp is set.
  - An accept-boundary increment and a new_dat decrement in the same cycle leave outstanding unchanged.
- Result forwarding is active in every state except reset.

Test Plan:
1. After rst, check IDLE outputs and avg_n_avgs=1. Then cfg_n_avgs=2 with cfg_update, enable=1 -> avg_n_avgs=2; SETTLE lasts 3 cycles; s_ready rises on the 4th cycle after entering SETTLE.
2. With n=2, stream x=10,20,30,40 and then model avg_new_dat with avg_y=25 -> avg_valid mirrors each accept one cycle later; m_valid=1, m_data=25, m_frame=0, and the next frame gives m_frame=1.
3. cfg_update n=3 after the 2nd sample of a frame -> samples 3 and 4 are still accepted; s_ready=0 in DRAIN until new_dat; avg_n_avgs=3 on SETTLE entry; the next frame takes 8 accepts.
4. enable=0 after the 1st sample of a frame (n=2) -> 3 more samples accepted, then DRAIN, then IDLE with s_ready=0.
5. Withhold avg_new_dat in DRAIN -> after 64 cycles err_timeout=1 and the state advances. A spurious avg_new_dat while IDLE -> err_unexp=1 and no m_valid.
6. cfg_n_avgs=200 -> avg_n_avgs=10. Also: rst during RUN mid-frame -> all outputs return to reset values on the next cycle, and the pending configuration is lost.

Source files
------------

// File: rtl/gsa_ctrl_if.sv
// Sample, averager and result signals of the growing-sum averager controller.
// master = controller side, slave = sample source / averager / readout side.
interface gsa_ctrl_if #(
  parameter int N       = 16,
  parameter int NAVG_W  = 8,
  parameter int FRAME_W = 16
);
  logic               s_valid;
  logic               s_ready;
  logic [N-1:0]       s_data;
  logic               avg_valid;
  logic [N-1:0]       avg_x;
  logic [NAVG_W-1:0]  avg_n_avgs;
  logic               avg_new_dat;
  logic [N-1:0]       avg_y;
  logic               m_valid;
  logic [N-1:0]       m_data;
  logic [FRAME_W-1:0] m_frame;

  modport master (
    input  s_valid, s_data, avg_new_dat, avg_y,
    output s_ready, avg_valid, avg_x, avg_n_avgs, m_valid, m_data, m_frame
  );

  modport slave (
    output s_valid, s_data, avg_new_dat, avg_y,
    input  s_ready, avg_valid, avg_x, avg_n_avgs, m_valid, m_data, m_frame
  );
endinterface

// File: rtl/gsa_ctrl.sv
// Sequencing controller for the signed growing-sum averager: whole-frame sample
// admission, boundary-aligned length changes with drain/settle, frame-tagged results.
module gsa_ctrl #(
  parameter int N             = 16,
  parameter int NAVG_W        = 8,
  parameter int MAX_LOG2      = 10,
  parameter int SETTLE_CYC    = 3,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int FRAME_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NAVG_W-1:0] cfg_n_avgs,
  input  logic              cfg_update,
  output logic              cfg_busy,
  gsa_ctrl_if.master        bus,
  output logic              err_unexp,
  output logic              err_timeout
);
  localparam int CNT_W = MAX_LOG2 + 1;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int DRN_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam int OUT_W = 8;

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [NAVG_W-1:0]  active, active_nxt, pend_val, cfg_clamped, n_avgs_q;
  logic               pend_vld;
  logic [CNT_W-1:0]   sample_cnt, frame_max;
  logic [SET_W-1:0]   settle_cnt;
  logic [DRN_W-1:0]   drain_cnt;
  logic [OUT_W-1:0]   outstanding;
  logic [FRAME_W-1:0] frame_idx, m_frame_q;
  logic [N-1:0]       avg_x_q, m_data_q;
  logic               avg_valid_q, m_valid_q;
  logic               accept, boundary, result_ok, drain_to, drain_exit;

  assign cfg_clamped = (cfg_n_avgs > NAVG_W'(MAX_LOG2)) ? NAVG_W'(MAX_LOG2) : cfg_n_avgs;
  assign frame_max   = (CNT_W'(1) << active) - CNT_W'(1);
  assign accept      = (state == RUN) & bus.s_valid;
  assign boundary    = accept & (sample_cnt == frame_max);
  assign result_ok   = bus.avg_new_dat & (outstanding != '0);
  assign drain_to    = (state == DRAIN) & (outstanding != '0) &
                       (drain_cnt == DRN_W'(DRAIN_TIMEOUT - 1));
  assign drain_exit  = (state == DRAIN) & ((outstanding == '0) | drain_to);

  assign bus.s_ready    = (state == RUN);
  assign bus.avg_valid  = avg_valid_q;
  assign bus.avg_x      = avg_x_q;
  assign bus.avg_n_avgs = n_avgs_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_frame    = m_frame_q;
  assign cfg_busy       = pend_vld | (state == DRAIN) | (state == SETTLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // active_nxt folds in a same-cycle cfg_update so SETTLE entry sees the new length
  always_comb begin
    state_nxt  = state;
    active_nxt = active;
    case (state)
      IDLE: begin
        if (cfg_update) active_nxt = cfg_clamped;
        if (enable)     state_nxt  = SETTLE;
      end
      SETTLE: if (settle_cnt == SET_W'(SETTLE_CYC - 1)) state_nxt = RUN;
      RUN: if (boundary & (pend_vld | cfg_update | ~enable)) state_nxt = DRAIN;
      DRAIN: if (drain_exit) begin
        if (cfg_update)    active_nxt = cfg_clamped;
        else if (pend_vld) active_nxt = pend_val;
        state_nxt = enable ? SETTLE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active      <= NAVG_W'(1);
      n_avgs_q    <= NAVG_W'(1);
      pend_vld    <= 1'b0;
      pend_val    <= '0;
      sample_cnt  <= '0;
      settle_cnt  <= '0;
      drain_cnt   <= '0;
      outstanding <= '0;
      frame_idx   <= '0;
      avg_valid_q <= 1'b0;
      avg_x_q     <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_frame_q   <= '0;
      err_unexp   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      active <= active_nxt;
      if ((state == IDLE) | drain_exit) pend_vld <= 1'b0;
      else if (cfg_update) begin
        pend_vld <= 1'b1;
        pend_val <= cfg_clamped;
      end
      if ((state != SETTLE) && (state_nxt == SETTLE)) begin
        n_avgs_q   <= active_nxt;
        settle_cnt <= '0;
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt + SET_W'(1);
      end
      if (state != RUN) sample_cnt <= '0;
      else if (accept)  sample_cnt <= boundary ? '0 : sample_cnt + CNT_W'(1);
      drain_cnt <= (state == DRAIN) ? drain_cnt + DRN_W'(1) : '0;
      if (drain_to) outstanding <= '0;
      else          outstanding <= outstanding + OUT_W'(boundary) - OUT_W'(result_ok);
      err_timeout <= err_timeout | drain_to;
      err_unexp   <= err_unexp | (bus.avg_new_dat & (outstanding == '0));
      avg_valid_q <= accept;
      if (accept) avg_x_q <= bus.s_data;
      m_valid_q <= result_ok;
      if (result_ok) begin
        m_data_q  <= bus.avg_y;
        m_frame_q <= frame_idx;
        frame_idx <= frame_idx + FRAME_W'(1);
      end
    end
  end
endmodule
